// File: rtl/memaccess_seq.sv
// Load/store memory-access sequencer: direct and indirect LD/ST with wait states.
// Optional I/O write guard enabled by defining MEMACCESS_SEQ_IOGUARD_EN.
module memaccess_seq #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [15:0] IO_BASE     = 16'hFE00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [15:0] DMem_out,
  output logic        MControl,
  output logic [15:0] MAddr,
  output logic [15:0] MData,
  output logic [1:0]  mem_state,
  output logic        ready,
  output logic        done,
  output logic [15:0] rdata,
  output logic        err
);

`ifdef MEMACCESS_SEQ_IOGUARD_EN
  localparam bit IOG = 1'b1;
`else
  localparam bit IOG = 1'b0;
`endif

  localparam logic [2:0] LAST = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    RD   = 2'b00,
    IND  = 2'b01,
    WR   = 2'b10,
    IDLE = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] maddr_q, maddr_d;
  logic [15:0] mdata_q, mdata_d;
  logic        mctl_q, mctl_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        pend_q, pend_d;
  logic        last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 3'd1;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    last    = (cnt_q == LAST);
    unique case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        if (pend_q) begin
          // a blocked direct store reports one cycle later
          pend_d = 1'b0;
          done_d = 1'b1;
          err_d  = 1'b1;
        end else if (start && ready_q) begin
          op_d    = op;
          addr_d  = addr;
          wdata_d = wdata;
          unique case (op)
            2'b00: state_d = RD;
            2'b01: begin
              if (IOG && addr >= IO_BASE) pend_d = 1'b1;
              else state_d = WR;
            end
            default: state_d = IND;
          endcase
        end
      end
      IND: begin
        if (last) begin
          addr_d = DMem_out;
          cnt_d  = 3'd0;
          if (!op_q[0]) begin
            state_d = RD;
          end else if (IOG && DMem_out >= IO_BASE) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = WR;
          end
        end
      end
      RD: begin
        if (last) begin
          rdata_d = DMem_out;
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = 3'd0;
        end
      end
      WR: begin
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = 3'd0;
        end
      end
    endcase
    ready_d = (state_d == IDLE) && !pend_d;
    mctl_d  = (state_d == IND);
    maddr_d = (state_d == IDLE) ? 16'h0 : addr_d;
    mdata_d = (state_d == WR) ? wdata_d : 16'h0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      op_q    <= 2'b00;
      addr_q  <= 16'h0;
      wdata_q <= 16'h0;
      rdata_q <= 16'h0;
      maddr_q <= 16'h0;
      mdata_q <= 16'h0;
      mctl_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      mctl_q  <= mctl_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  assign mem_state = state_q;
  assign MControl  = mctl_q;
  assign MAddr     = maddr_q;
  assign MData     = mdata_q;
  assign ready     = ready_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_memaccess_seq.sv
// Bench for memaccess_seq: WAIT_CYCLES=0 and WAIT_CYCLES=2 instances,
// cycle-by-cycle model comparison plus hand-computed literal checks.
module tb_memaccess_seq;

  typedef struct packed {
    logic [1:0]  ms;
    logic        mc;
    logic [15:0] ma;
    logic [15:0] md;
    logic        rdy;
    logic        dn;
    logic        er;
    logic [15:0] rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st  [2];
  logic [1:0]  opv [2];
  logic [15:0] av  [2];
  logic [15:0] wv  [2];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [15:0] a);
    case (a)
      16'h3000: return 16'hBEEF;
      16'h3010: return 16'h4000;
      16'h4000: return 16'h1234;
      16'h3020: return 16'h5000;
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  function automatic exp_t mk(input logic [1:0] ms, input logic mc,
                              input logic [15:0] ma, input logic [15:0] md,
                              input logic rdy, input logic dn, input logic er,
                              input logic [15:0] rd);
    exp_t e;
    e.ms = ms; e.mc = mc; e.ma = ma; e.md = md;
    e.rdy = rdy; e.dn = dn; e.er = er; e.rd = rd;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int W = (k == 0) ? 0 : 2;
    logic [1:0]  ms;
    logic        mc, rdy, dn, er;
    logic [15:0] ma, md, rd, dm;
    exp_t        q[$];
    exp_t        cur, e;
    logic [15:0] rdm = 16'h0;

    assign dm = memf(ma);

    memaccess_seq #(.WAIT_CYCLES(W)) dut (
      .clock(clk), .reset(rst), .start(st[k]), .op(opv[k]),
      .addr(av[k]), .wdata(wv[k]), .DMem_out(dm),
      .MControl(mc), .MAddr(ma), .MData(md), .mem_state(ms),
      .ready(rdy), .done(dn), .rdata(rd), .err(er)
    );

    task automatic push(input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] w);
      logic [15:0] ea;
      ea = a;
      if (o[1]) begin
        for (int i = 0; i <= W; i++)
          q.push_back(mk(2'b01, 1'b1, a, 16'h0, 1'b0, 1'b0, 1'b0, rdm));
        ea = memf(a);
      end
`ifdef MEMACCESS_SEQ_IOGUARD_EN
      if (o[0] && ea >= 16'hFE00) begin
        if (!o[1])
          q.push_back(mk(2'b11, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, rdm));
        q.push_back(mk(2'b11, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1, rdm));
        return;
      end
`endif
      if (!o[0]) begin
        for (int i = 0; i <= W; i++)
          q.push_back(mk(2'b00, 1'b0, ea, 16'h0, 1'b0, 1'b0, 1'b0, rdm));
        rdm = memf(ea);
      end else begin
        for (int i = 0; i <= W; i++)
          q.push_back(mk(2'b10, 1'b0, ea, w, 1'b0, 1'b0, 1'b0, rdm));
      end
      q.push_back(mk(2'b11, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, rdm));
    endtask

    initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        rdm = 16'h0;
      end else begin
        cur = (q.size() != 0) ? q[0]
            : mk(2'b11, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, rdm);
        if (q.size() != 0) void'(q.pop_front());
        if (cur.rdy && st[k]) push(opv[k], av[k], wv[k]);
      end
    end

    initial forever begin
      @(negedge clk);
      e = (q.size() != 0) ? q[0]
        : mk(2'b11, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, rdm);
      chk($sformatf("g%0d mem_state", k), 16'(ms), 16'(e.ms));
      chk($sformatf("g%0d MControl", k), 16'(mc), 16'(e.mc));
      chk($sformatf("g%0d MAddr", k), ma, e.ma);
      chk($sformatf("g%0d MData", k), md, e.md);
      chk($sformatf("g%0d ready", k), 16'(rdy), 16'(e.rdy));
      chk($sformatf("g%0d done", k), 16'(dn), 16'(e.dn));
      chk($sformatf("g%0d err", k), 16'(er), 16'(e.er));
      chk($sformatf("g%0d rdata", k), rd, e.rd);
    end
  end

  task automatic issue(input int k, input logic [1:0] o,
                       input logic [15:0] a, input logic [15:0] w);
    @(posedge clk); #1;
    st[k] = 1'b1; opv[k] = o; av[k] = a; wv[k] = w;
    @(posedge clk); #1;
    st[k] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; opv[i] = 2'b00; av[i] = 16'h0; wv[i] = 16'h0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset ready", 16'(g[0].rdy), 16'h1);
    chk("reset state", 16'(g[1].ms), 16'h3);
    chk("reset rdata", g[0].rd, 16'h0);

    // LD, no wait states
    issue(0, 2'b00, 16'h3000, 16'h0);
    @(negedge clk);
    chk("ld ms", 16'(g[0].ms), 16'h0);
    chk("ld maddr", g[0].ma, 16'h3000);
    @(negedge clk);
    chk("ld done", 16'(g[0].dn), 16'h1);
    chk("ld rdata", g[0].rd, 16'hBEEF);

    // LDI with two wait states
    issue(1, 2'b10, 16'h3010, 16'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ldi ind ms", 16'(g[1].ms), 16'h1);
      chk("ldi ind mctl", 16'(g[1].mc), 16'h1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ldi rd ms", 16'(g[1].ms), 16'h0);
      chk("ldi rd maddr", g[1].ma, 16'h4000);
    end
    @(negedge clk);
    chk("ldi done", 16'(g[1].dn), 16'h1);
    chk("ldi rdata", g[1].rd, 16'h1234);

    // STI
    issue(0, 2'b11, 16'h3020, 16'hA5A5);
    @(negedge clk);
    chk("sti ind ms", 16'(g[0].ms), 16'h1);
    @(negedge clk);
    chk("sti wr ms", 16'(g[0].ms), 16'h2);
    chk("sti maddr", g[0].ma, 16'h5000);
    chk("sti mdata", g[0].md, 16'hA5A5);
    @(negedge clk);
    chk("sti done", 16'(g[0].dn), 16'h1);
    chk("sti err", 16'(g[0].er), 16'h0);

    // back-to-back: ST issued in the done cycle of a LD
    issue(0, 2'b00, 16'h3000, 16'h0);
    @(posedge clk); #1;
    chk("b2b done", 16'(g[0].dn), 16'h1);
    st[0] = 1'b1; opv[0] = 2'b01; av[0] = 16'h6000; wv[0] = 16'h1111;
    @(posedge clk); #1;
    st[0] = 1'b0;
    @(negedge clk);
    chk("b2b wr ms", 16'(g[0].ms), 16'h2);
    chk("b2b maddr", g[0].ma, 16'h6000);
    chk("b2b mdata", g[0].md, 16'h1111);
    repeat (3) @(posedge clk);

    // store into device-register space
    issue(0, 2'b01, 16'hFE02, 16'h7777);
`ifdef MEMACCESS_SEQ_IOGUARD_EN
    @(negedge clk);
    chk("io ms", 16'(g[0].ms), 16'h3);
    @(negedge clk);
    chk("io done", 16'(g[0].dn), 16'h1);
    chk("io err", 16'(g[0].er), 16'h1);
`else
    @(negedge clk);
    chk("io ms", 16'(g[0].ms), 16'h2);
    chk("io maddr", g[0].ma, 16'hFE02);
    @(negedge clk);
    chk("io done", 16'(g[0].dn), 16'h1);
    chk("io err", 16'(g[0].er), 16'h0);
`endif
    repeat (2) @(posedge clk);

    // more traffic on the wait-state instance
    issue(1, 2'b01, 16'h2000, 16'h0F0F);
    repeat (5) @(posedge clk);
    issue(1, 2'b11, 16'h3020, 16'h3C3C);
    repeat (8) @(posedge clk);
    issue(1, 2'b00, 16'h0042, 16'h0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("ld default rdata", g[1].rd, 16'h5A18);

    // reset during the pointer phase of an LDI
    issue(1, 2'b10, 16'h3010, 16'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst ms", 16'(g[1].ms), 16'h3);
    chk("rst mctl", 16'(g[1].mc), 16'h0);
    chk("rst maddr", g[1].ma, 16'h0);
    chk("rst ready", 16'(g[1].rdy), 16'h1);
    chk("rst rdata", g[1].rd, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("post rst ready", 16'(g[1].rdy), 16'h1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
